// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command-driven RAM behind an SPI-style byte stream.
// The rx_data word carries a 2-bit command and a payload. Addresses are loaded with
// WRITE_ADD and READ_ADD. WRITE_DATA stores a word. READ_DATA returns one word on a
// valid/ready tx port with a latency of one cycle.
// Optional feature: define SPI_RAM_AUTO_INC_EN to enable address auto-increment.
// With it, addr_wr advances after each WRITE_DATA and addr_rd after each accepted READ_DATA.
module spi_ram_burst #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W+1:0] rx_data,
   input  logic              rx_valid,
   input  logic              tx_ready,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   output logic              err_overrun
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      CMD_WRITE_ADD  = 2'b00,
      CMD_WRITE_DATA = 2'b01,
      CMD_READ_ADD   = 2'b10,
      CMD_READ_DATA  = 2'b11
   } cmd_e;

   cmd_e              cmd;
   logic [DATA_W-1:0] payload;
   logic [ADDR_W-1:0] payload_addr;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] addr_wr;
   logic [ADDR_W-1:0] addr_rd;
   logic [ADDR_W-1:0] addr_wr_next;
   logic [ADDR_W-1:0] addr_rd_next;

   logic wr_add_en;
   logic wr_data_en;
   logic rd_add_en;
   logic rd_req;
   logic xfer;
   logic rd_vld_p0;
   logic rd_drop;

   assign cmd          = cmd_e'(rx_data[DATA_W+1:DATA_W]);
   assign payload      = rx_data[DATA_W-1:0];
   assign payload_addr = payload[ADDR_W-1:0];

`ifdef SPI_RAM_AUTO_INC_EN
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   assign addr_wr_next = addr_wr + ADDR_ONE;
   assign addr_rd_next = addr_rd + ADDR_ONE;
`else
   assign addr_wr_next = addr_wr;
   assign addr_rd_next = addr_rd;
`endif

   // Command decode. A read is taken when the output slot is empty or is being drained this cycle.
   // Otherwise the read is dropped.
   always_comb begin
      wr_add_en  = 1'b0;
      wr_data_en = 1'b0;
      rd_add_en  = 1'b0;
      rd_req     = 1'b0;
      if (rx_valid) begin
         case (cmd)
            CMD_WRITE_ADD:  wr_add_en  = 1'b1;
            CMD_WRITE_DATA: wr_data_en = 1'b1;
            CMD_READ_ADD:   rd_add_en  = 1'b1;
            CMD_READ_DATA:  rd_req     = 1'b1;
            default:        rd_req     = 1'b0;
         endcase
      end
      xfer      = tx_valid & tx_ready;
      rd_vld_p0 = rd_req & (~tx_valid | tx_ready);
      rd_drop   = rd_req & tx_valid & ~tx_ready;
   end

   // Memory write port. The array is never reset, but no write is performed during reset.
   always_ff @(posedge clk) begin
      if (rst_n && wr_data_en) begin
         mem[addr_wr] <= payload;
      end
   end

   // Address registers, the tx output stage and the sticky overrun flag. Reset takes priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_wr     <= '0;
         addr_rd     <= '0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         if (wr_add_en) begin
            addr_wr <= payload_addr;
         end else if (wr_data_en) begin
            addr_wr <= addr_wr_next;
         end

         if (rd_add_en) begin
            addr_rd <= payload_addr;
         end else if (rd_vld_p0) begin
            addr_rd <= addr_rd_next;
         end

         // ---- stage p1: registered read data ----
         if (rd_vld_p0) begin
            tx_data  <= mem[addr_rd];
            tx_valid <= 1'b1;
         end else if (xfer) begin
            tx_valid <= 1'b0;
         end

         if (rd_drop) begin
            err_overrun <= 1'b1;
         end
      end
   end

endmodule

// File: doc/spi_ram_burst.md
SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload and memory word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning address width; memory depth is 2**ADDR_W; ADDR_W <= DATA_W is required.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_data  input  DATA_W+2  bits [DATA_W+1:DATA_W] command, bits [DATA_W-1:0] payload.
REQ-006 SHALL have port rx_valid  input  1  rx_data qualifier, one command per cycle.
REQ-007 SHALL have port tx_ready  input  1  downstream accepts tx_data.
REQ-008 SHALL have port tx_data  output  DATA_W  registered read data.
REQ-009 SHALL have port tx_valid  output  1  tx_data valid, held until accepted.
REQ-010 SHALL have port err_overrun  output  1  sticky flag for a dropped read request.

Function
REQ-011 SHALL decode commands only when rx_valid=1: 00 WRITE_ADD, 01 WRITE_DATA, 10 READ_ADD, 11 READ_DATA; with rx_valid=0, no state changes except the handshake in REQ-016.
REQ-012 SHALL, on WRITE_ADD, load addr_wr <= payload[ADDR_W-1:0]; payload bits above ADDR_W are ignored.
REQ-013 SHALL, on WRITE_DATA, write mem[addr_wr] <= payload at that clock edge.
REQ-014 SHALL, on READ_ADD, load addr_rd <= payload[ADDR_W-1:0].
REQ-015 SHALL, on an accepted READ_DATA, present mem[addr_rd] on tx_data with tx_valid=1 on the next cycle (latency 1).
REQ-016 SHALL define a transfer as tx_valid=1 && tx_ready=1; after a transfer, tx_valid SHALL fall next cycle unless a new read loads in the same cycle.
REQ-017 SHALL accept READ_DATA when tx_valid=0 or a transfer occurs in the same cycle; tx_valid then stays 1 and tx_data updates.
REQ-018 SHALL drop READ_DATA received while tx_valid=1 and tx_ready=0: tx_data is held, addr_rd is unchanged and err_overrun is set.
REQ-019 SHALL keep err_overrun set until reset.
REQ-020 SHALL return the newly written value when WRITE_DATA is followed next cycle by READ_DATA to the same address.
REQ-021 SHALL leave WRITE_ADD, WRITE_DATA and READ_ADD unaffected by tx backpressure.

Reset
REQ-022 SHALL, on a clk edge with rst_n=0, set tx_data=0, tx_valid=0, err_overrun=0, addr_wr=0 and addr_rd=0.
REQ-023 SHALL discard a pending read on reset; the memory array is not reset and keeps its contents through reset.
REQ-024 SHALL give reset priority over any simultaneous command or transfer.

Configuration
REQ-025 SHALL, with macro SPI_RAM_AUTO_INC_EN defined, post-increment addr_wr after each WRITE_DATA and addr_rd after each accepted READ_DATA, modulo 2**ADDR_W.
REQ-026 SHALL, without SPI_RAM_AUTO_INC_EN, hold addr_wr and addr_rd until the next WRITE_ADD or READ_ADD.

Verification (DATA_W=8, ADDR_W=8)
REQ-027 Scenario: WRITE_ADD 0x10, WRITE_DATA 0xA5, READ_ADD 0x10, READ_DATA with tx_ready=1 -> tx_data=0xA5 and tx_valid=1 exactly one cycle after READ_DATA, then tx_valid=0.
REQ-028 Scenario (macro defined): WRITE_ADD 0xFF, WRITE_DATA 0x11, WRITE_DATA 0x22, READ_ADD 0xFF, two READ_DATA -> 0x11 then 0x22 (wrap to 0x00).
REQ-029 Scenario: tx_ready=0, READ_DATA twice -> tx_data holds the first word, err_overrun=1, and after tx_ready=1 the next READ_DATA returns the address following the first read only (macro defined).
REQ-030 Scenario: tx_valid=1 pending, rst_n=0 for one cycle -> tx_valid=0, err_overrun=0; read of a previously written address returns its pre-reset data.
REQ-031 Scenario: rx_data command 11 with rx_valid=0 -> tx_valid stays 0 and addr_rd is unchanged.
REQ-032 Scenario (macro undefined): READ_ADD 0x10 followed by two READ_DATA -> both return mem[0x10].
